// File: rtl/pulse_train_gen_if.sv
// Bundles the run controls, phase lengths and generated outputs of pulse_train_gen.
// master drives controls and lengths; slave is the generator itself.
interface pulse_train_gen_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             trig_enable;
    logic             trig_in;
    logic             cfg_out_inv;
    logic             cfg_trig_out;
    logic [CNT_W-1:0] d1_len;
    logic [CNT_W-1:0] d2_len;
    logic [CNT_W-1:0] d3_len;
    logic             gpio_out;
    logic             trig_out;
    logic             busy;
    logic             done;

    modport master (
        output enable, trig_enable, trig_in, cfg_out_inv, cfg_trig_out,
        output d1_len, d2_len, d3_len,
        input  gpio_out, trig_out, busy, done
    );

    modport slave (
        input  enable, trig_enable, trig_in, cfg_out_inv, cfg_trig_out,
        input  d1_len, d2_len, d3_len,
        output gpio_out, trig_out, busy, done
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Three-phase pulse generator: active d1, inactive d2, active d3 clks, then DONE.
// Lengths are captured at the start event; every output is registered from next-state.
//
//  state  | meaning
//  IDLE   | not running, waiting for enable
//  ARMED  | enabled, waiting for trig_in
//  PH1    | first active phase, d1 clks
//  PH2    | inactive gap, d2 clks
//  PH3    | second active phase, d3 clks
//  DONE   | run finished, held until enable drops
module pulse_train_gen #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    pulse_train_gen_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_PH1,
        S_PH2,
        S_PH3,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    state_t           first_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] d1_q, d1_d;
    logic [CNT_W-1:0] d2_q, d2_d;
    logic [CNT_W-1:0] d3_q, d3_d;
    logic             gpio_q, gpio_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start;

    // Entry state for a new run, decided from the live lengths being captured.
    always_comb begin
        first_state = S_DONE;
        if (bus.d1_len != '0)      first_state = S_PH1;
        else if (bus.d2_len != '0) first_state = S_PH2;
        else if (bus.d3_len != '0) first_state = S_PH3;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        trig_d  = 1'b0;
        start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    if (bus.trig_enable) state_d = S_ARMED;
                    else                 start   = 1'b1;
                end
            end
            S_ARMED: begin
                if (bus.trig_in) start = 1'b1;
            end
            S_PH1: begin
                if (cnt_q == d1_q) begin
                    cnt_d  = CNT_W'(1);
                    trig_d = bus.cfg_trig_out;
                    if (d2_q != '0)      state_d = S_PH2;
                    else if (d3_q != '0) state_d = S_PH3;
                    else                 state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PH2: begin
                if (cnt_q == d2_q) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (d3_q != '0) ? S_PH3 : S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PH3: begin
                if (cnt_q == d3_q) begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start) begin
            d1_d    = bus.d1_len;
            d2_d    = bus.d2_len;
            d3_d    = bus.d3_len;
            cnt_d   = CNT_W'(1);
            state_d = first_state;
            // End-of-PH1 trigger collapses onto the start when PH1 is skipped.
            trig_d  = !bus.cfg_trig_out || (bus.d1_len == '0);
        end

        if (!bus.enable) begin
            state_d = S_IDLE;
            trig_d  = 1'b0;
        end

        gpio_d = ((state_d == S_PH1) || (state_d == S_PH3)) ^ bus.cfg_out_inv;
        busy_d = (state_d == S_ARMED) || (state_d == S_PH1) ||
                 (state_d == S_PH2)   || (state_d == S_PH3);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            gpio_q  <= 1'b0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            gpio_q  <= gpio_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.gpio_out = gpio_q;
    assign bus.trig_out = trig_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: fixed and random runs compared against
// a timeline model computed from the phase lengths with plain arithmetic.
module tb_pulse_train_gen;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    pulse_train_gen_if #(.CNT_W(32)) bus_if ();

    pulse_train_gen #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gpio_out, trig_out, busy, done} for clk c after the start edge (c >= 1).
    function automatic logic [3:0] exp_out(int c, int d1, int d2, int d3, bit inv, bit tcfg);
        int total;
        bit act, trg, bsy, dn;
        total = d1 + d2 + d3;
        act   = (c >= 1 && c <= d1) || (c > d1 + d2 && c <= total);
        trg   = tcfg ? (c == d1 + 1) : (c == 1);
        bsy   = (c >= 1 && c <= total);
        dn    = (c > total);
        return {act ^ inv, trg, bsy, dn};
    endfunction

    function automatic logic [3:0] observed();
        return {bus_if.gpio_out, bus_if.trig_out, bus_if.busy, bus_if.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_lengths();
        bus_if.d1_len = $urandom;
        bus_if.d2_len = $urandom;
        bus_if.d3_len = $urandom;
    endtask

    task automatic set_lengths(int d1, int d2, int d3);
        bus_if.d1_len = 32'(d1);
        bus_if.d2_len = 32'(d2);
        bus_if.d3_len = 32'(d3);
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        bus_if.enable       = 1'b1;
        bus_if.trig_enable  = 1'b0;
        bus_if.trig_in      = 1'b0;
        bus_if.cfg_out_inv  = 1'b1;
        bus_if.cfg_trig_out = 1'b0;
        set_lengths(2, 2, 2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = observed();
            n_vec++;
            if (obs !== 4'b0000) begin
                n_err++;
                $display("FAIL reset cyc%0d: got %b want 0000", i, obs);
            end
        end
        bus_if.enable = 1'b0;
        rst = 1'b0;
        tick();
        obs = observed();
        n_vec++;
        if (obs !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_idle_inv: got %b want 1000", obs);
        end
    endtask

    // Free-running (no trigger) runs: fixed cases first, then random ones.
    task automatic test_free_run();
        int d1, d2, d3, total;
        bit inv, tcfg;
        logic [3:0] obs, exp;
        for (int r = 0; r < 16; r++) begin
            case (r)
                0:       begin d1 = 3; d2 = 2; d3 = 4; inv = 0; tcfg = 0; end
                1:       begin d1 = 5; d2 = 2; d3 = 1; inv = 0; tcfg = 1; end
                2:       begin d1 = 0; d2 = 3; d3 = 2; inv = 0; tcfg = 1; end
                3:       begin d1 = 0; d2 = 0; d3 = 0; inv = 1; tcfg = 0; end
                4:       begin d1 = 0; d2 = 0; d3 = 0; inv = 0; tcfg = 1; end
                5:       begin d1 = 1; d2 = 0; d3 = 1; inv = 1; tcfg = 1; end
                default: begin
                    d1   = $urandom_range(0, 6);
                    d2   = $urandom_range(0, 6);
                    d3   = $urandom_range(0, 6);
                    inv  = 1'($urandom_range(0, 1));
                    tcfg = 1'($urandom_range(0, 1));
                end
            endcase
            total = d1 + d2 + d3;
            bus_if.enable       = 1'b0;
            bus_if.trig_enable  = 1'b0;
            bus_if.cfg_out_inv  = inv;
            bus_if.cfg_trig_out = tcfg;
            tick();
            obs = observed();
            n_vec++;
            if (obs !== {inv, 3'b000}) begin
                n_err++;
                $display("FAIL free_idle run%0d: got %b want %b", r, obs, {inv, 3'b000});
            end
            set_lengths(d1, d2, d3);
            bus_if.enable = 1'b1;
            for (int c = 1; c <= total + 3; c++) begin
                tick();
                scramble_lengths();
                obs = observed();
                exp = exp_out(c, d1, d2, d3, inv, tcfg);
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL free_run run%0d d=%0d/%0d/%0d clk%0d: got %b want %b",
                             r, d1, d2, d3, c, obs, exp);
                end
            end
        end
        bus_if.enable = 1'b0;
        tick();
    endtask

    task automatic test_armed();
        logic [3:0] obs, exp;
        bus_if.cfg_out_inv  = 1'b0;
        bus_if.cfg_trig_out = 1'b0;
        bus_if.trig_enable  = 1'b1;
        bus_if.trig_in      = 1'b0;
        set_lengths(3, 2, 4);
        bus_if.enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            obs = observed();
            n_vec++;
            if (obs !== 4'b0010) begin
                n_err++;
                $display("FAIL armed_wait clk%0d: got %b want 0010", i, obs);
            end
        end
        bus_if.trig_in = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            bus_if.trig_in = 1'b0;
            scramble_lengths();
            obs = observed();
            exp = exp_out(c, 3, 2, 4, 1'b0, 1'b0);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL armed_run clk%0d: got %b want %b", c, obs, exp);
            end
        end
        bus_if.enable      = 1'b0;
        bus_if.trig_enable = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [3:0] obs, exp;
        bus_if.cfg_out_inv  = 1'b1;
        bus_if.cfg_trig_out = 1'b1;
        bus_if.trig_enable  = 1'b0;
        set_lengths(2, 100, 3);
        bus_if.enable = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            obs = observed();
            exp = exp_out(c, 2, 100, 3, 1'b1, 1'b1);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL abort_pre clk%0d: got %b want %b", c, obs, exp);
            end
        end
        bus_if.enable = 1'b0;
        tick();
        obs = observed();
        n_vec++;
        if (obs !== 4'b1000) begin
            n_err++;
            $display("FAIL abort_idle: got %b want 1000", obs);
        end
        set_lengths(1, 2, 2);
        bus_if.enable = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            scramble_lengths();
            obs = observed();
            exp = exp_out(c, 1, 2, 2, 1'b1, 1'b1);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL abort_rerun clk%0d: got %b want %b", c, obs, exp);
            end
        end
        bus_if.enable = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid();
        logic [3:0] obs, exp;
        bus_if.cfg_out_inv  = 1'b1;
        bus_if.cfg_trig_out = 1'b0;
        bus_if.trig_enable  = 1'b0;
        set_lengths(10, 1, 1);
        bus_if.enable = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            set_lengths(2, 1, 3);
            obs = observed();
            exp = exp_out(c, 10, 1, 1, 1'b1, 1'b0);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rst_pre clk%0d: got %b want %b", c, obs, exp);
            end
        end
        rst = 1'b1;
        tick();
        obs = observed();
        n_vec++;
        if (obs !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_mid: got %b want 0000", obs);
        end
        rst = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            scramble_lengths();
            obs = observed();
            exp = exp_out(c, 2, 1, 3, 1'b1, 1'b0);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL rst_rerun clk%0d: got %b want %b", c, obs, exp);
            end
        end
        bus_if.enable = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        test_reset();
        test_free_run();
        test_armed();
        test_abort();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
